instruction_fetch_controller: RTL and testbench
===============================================

INSTRUCTION_FETCH_CONTROLLER -- requirements
Module: instruction_fetch_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch byte address after reset.
REQ-003 Parameter PC_LIMIT, default 32'd16, first byte address not fetched (program end).
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port reset  input  1  asynchronous, active-low; 0 = in reset.
REQ-006 Port imem_addr  output  32  byte address to instruction memory (drives its PC input).
REQ-007 Port imem_data  input  32  instruction word at imem_addr; combinational, valid in the same cycle.
REQ-008 Port redirect_valid  input  1  branch/jump redirect request, sampled on clk.
REQ-009 Port redirect_pc  input  32  redirect target byte address.
REQ-010 Port instr_valid  output  1  FIFO head holds a valid instruction.
REQ-011 Port instr_ready  input  1  decode accepts head; transfer when instr_valid && instr_ready.
REQ-012 Port instr_data  output  32  FIFO head instruction word.
REQ-013 Port instr_pc  output  32  FIFO head byte address.
REQ-014 Port halted  output  1  state HALT and FIFO empty.

Function
REQ-015 The block SHALL hold fetch_pc (32 bit), a 2-entry FIFO of {pc, word}, and a state machine with states RUN and HALT.
REQ-016 imem_addr SHALL equal fetch_pc combinationally at all times.
REQ-017 push condition: state RUN && (FIFO not full || pop this cycle) && !redirect_valid; a push SHALL store {fetch_pc, imem_data} and set fetch_pc <= fetch_pc + 4, with modulo-2^32 wrap.
REQ-018 pop condition: instr_valid && instr_ready; a pop SHALL remove the head on the same edge.
REQ-019 Simultaneous push and pop on a full FIFO SHALL be legal; occupancy stays 2.
REQ-020 Simultaneous push and pop on an empty FIFO SHALL NOT occur, because instr_valid is 0.
REQ-021 RUN -> HALT SHALL occur on the edge where the pushed fetch_pc + 4 >= PC_LIMIT, or where fetch_pc >= PC_LIMIT with no push; in HALT there SHALL be no pushes.
REQ-022 instr_valid, instr_data and instr_pc SHALL be driven directly from the FIFO head, with no combinational path from imem_data.
REQ-023 When FIFO is empty, instr_data and instr_pc SHALL be 0.
REQ-024 Redirect has top priority; on an edge with redirect_valid=1, the block SHALL:
  - flush the FIFO to empty, even if a pop handshake occurs in the same cycle (that pop counts as consumed);
  - set fetch_pc <= {redirect_pc[31:2], 2'b00}, with misaligned low bits forced to 0;
  - enter RUN if the aligned target < PC_LIMIT, else HALT;
  - perform no push that cycle.
REQ-025 A redirect SHALL be accepted in either state, allowing restart from HALT.
REQ-026 Fetch-to-issue latency SHALL be 1 cycle: a word pushed at edge N appears at instr_data after edge N.
REQ-027 instr_ready=0 SHALL stall fetch once FIFO is full, with fetch_pc held constant.
REQ-028 halted SHALL be combinational from state and FIFO occupancy.

Reset
REQ-029 While reset=0, the block SHALL force: fetch_pc=RESET_PC, FIFO empty, state RUN (HALT if RESET_PC >= PC_LIMIT), instr_valid=0, instr_data=0, instr_pc=0, halted=0 (1 if state HALT).
REQ-030 Reset assertion mid-operation SHALL discard FIFO contents immediately, asynchronously, without waiting for a clock edge.
REQ-031 The first push SHALL occur on the first rising clk edge after reset deasserts.

Verification
REQ-032 Streaming: memory holds 0x00940333, 0x413903b3, 0x035a02b3, 0x037b4e33 at 0/4/8/12; instr_ready=1 -> the block issues (pc, word) (0, 0x00940333), (4, 0x413903b3), (8, 0x035a02b3), (12, 0x037b4e33) on 4 consecutive cycles, then halted=1 with imem_addr=16.
REQ-033 Backpressure: instr_ready=0 after reset -> FIFO fills with pc 0 and 4, imem_addr holds 8; instr_ready=1 -> the block issues pc 0, 4, 8, 12 in order, with none dropped or duplicated.
REQ-034 Redirect with pop: FIFO holds pc 4 and 8, instr_ready=1, redirect_valid=1, redirect_pc=0x2 -> FIFO empty and imem_addr=0 next cycle; the following cycle instr_pc=0, instr_data=0x00940333.
REQ-035 Redirect from HALT: after halt, redirect_pc=8 -> RUN, halted=0, the block issues pc 8 then 12, then halted=1; redirect_pc=16 -> stays HALT with halted=1.
REQ-036 Async reset mid-stream: reset=0 between edges while FIFO holds 2 entries -> instr_valid=0 and imem_addr=0 before the next edge; after release the block issues pc 0 first.

Source files
------------

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch front end: walks fetch_pc through instruction memory and
// buffers {pc, word} pairs in a 2-entry FIFO toward decode, with redirect and halt.
module instruction_fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_LIMIT = 32'd16
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic        halted
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    localparam state_e RESET_STATE = (RESET_PC >= PC_LIMIT) ? HALT : RUN;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    entry_t      fifo_q [2];
    entry_t      fifo_d [2];
    logic [1:0]  count_q, count_d;

    logic        pop;
    logic        push;
    logic        wr_idx;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_aligned;

    assign pop              = (count_q != 2'd0) && instr_ready;
    assign push             = (state_q == RUN) && ((count_q != 2'd2) || pop) && !redirect_valid;
    assign pc_plus4         = fetch_pc_q + 32'd4;
    assign redirect_aligned = redirect_pc & ~32'd3;
    // Slot the new word lands in once the head (if popped) has shifted out.
    assign wr_idx           = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);

    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        fifo_d     = fifo_q;
        count_d    = count_q;

        if (redirect_valid) begin
            count_d    = 2'd0;
            fetch_pc_d = redirect_aligned;
            state_d    = (redirect_aligned < PC_LIMIT) ? RUN : HALT;
        end else begin
            if (pop) begin
                fifo_d[0] = fifo_q[1];
            end
            if (push) begin
                fifo_d[wr_idx] = '{pc: fetch_pc_q, word: imem_data};
                fetch_pc_d     = pc_plus4;
                if (pc_plus4 >= PC_LIMIT) begin
                    state_d = HALT;
                end
            end else if ((state_q == RUN) && (fetch_pc_q >= PC_LIMIT)) begin
                state_d = HALT;
            end
            count_d = count_q - {1'b0, pop} + {1'b0, push};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values seen at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RESET_STATE;
            fetch_pc_q <= RESET_PC;
            count_q    <= 2'd0;
            // NOTE: FIFO storage is only two entries, so clearing it on reset is
            // cheap and keeps the head deterministic; larger memories would not.
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            fifo_q     <= fifo_d;
        end
    end

    assign imem_addr   = fetch_pc_q;
    assign instr_valid = (count_q != 2'd0);
    assign instr_pc    = instr_valid ? fifo_q[0].pc : 32'd0;
    assign instr_data  = instr_valid ? fifo_q[0].word : 32'd0;
    assign halted      = (state_q == HALT) && (count_q == 2'd0);

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared each
// cycle against a queue-based behavioural model of the fetch controller.
module tb_instruction_fetch_controller;

    localparam logic [31:0] LIMIT = 32'd16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h0094_0333;
            32'd4:   return 32'h4139_03b3;
            32'd8:   return 32'h035a_02b3;
            32'd12:  return 32'h037b_4e33;
            default: return a ^ 32'hDEAD_BEEF;
        endcase
    endfunction

    assign imem_data = mem_word(imem_addr);

    instruction_fetch_controller #(
        .RESET_PC(32'h0000_0000),
        .PC_LIMIT(LIMIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc),
        .halted        (halted)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } item_t;

    item_t       mq[$];
    logic [31:0] m_pc;
    bit          m_run;
    logic [31:0] issued[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc  = 32'd0;
        m_run = (32'd0 < LIMIT);
    endtask

    // One clock edge of the fetch rules, applied to the model.
    task automatic model_edge(input logic rv, input logic [31:0] rp, input logic rdy);
        bit pop;
        bit do_push;
        pop = (mq.size() > 0) && rdy;
        if (rv) begin
            mq.delete();
            m_pc  = rp & ~32'd3;
            m_run = (m_pc < LIMIT);
        end else begin
            do_push = m_run && ((mq.size() < 2) || pop);
            if (pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back('{pc: m_pc, word: mem_word(m_pc)});
                m_pc = m_pc + 32'd4;
                if (m_pc >= LIMIT) m_run = 0;
            end else if (m_run && (m_pc >= LIMIT)) begin
                m_run = 0;
            end
        end
    endtask

    task automatic compare(input string where);
        bit empty;
        empty = (mq.size() == 0);
        check({where, ".imem_addr"}, imem_addr, m_pc);
        check({where, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, !empty});
        check({where, ".instr_pc"}, instr_pc, empty ? 32'd0 : mq[0].pc);
        check({where, ".instr_data"}, instr_data, empty ? 32'd0 : mq[0].word);
        check({where, ".halted"}, {31'd0, halted}, {31'd0, (!m_run && empty)});
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic step(input logic rv, input logic [31:0] rp, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rp;
        instr_ready    = rdy;
        @(negedge clk);
        compare("cyc");
        if (instr_valid && rdy) issued.push_back(instr_pc);
        @(posedge clk);
        model_edge(rv, rp, rdy);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        instr_ready    = 1'b0;
        model_reset();
        @(negedge clk);
        compare("in_reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        issued.delete();
    endtask

    task automatic check_issued(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3, input int n);
        logic [31:0] exp_list [4];
        exp_list = '{e0, e1, e2, e3};
        check({tag, ".count"}, issued.size(), n);
        for (int i = 0; i < n && i < issued.size(); i++) begin
            check({tag, ".pc"}, issued[i], exp_list[i]);
        end
    endtask

    initial begin
        do_reset();

        // Streaming with decode always ready.
        repeat (6) step(1'b0, 32'd0, 1'b1);
        check_issued("stream", 32'd0, 32'd4, 32'd8, 32'd12, 4);
        check("stream.halted", {31'd0, halted}, 32'd1);
        check("stream.imem_addr", imem_addr, 32'd16);

        // Restart from HALT, then a redirect past the end keeps it halted.
        issued.delete();
        step(1'b1, 32'd8, 1'b1);
        check("restart.halted", {31'd0, halted}, 32'd0);
        repeat (4) step(1'b0, 32'd0, 1'b1);
        check_issued("restart", 32'd8, 32'd12, 32'd0, 32'd0, 2);
        check("restart.halted_end", {31'd0, halted}, 32'd1);
        step(1'b1, 32'd16, 1'b1);
        step(1'b0, 32'd0, 1'b1);
        check("redir_limit.halted", {31'd0, halted}, 32'd1);

        // Backpressure: FIFO fills and fetch stalls, then drains in order.
        do_reset();
        repeat (3) step(1'b0, 32'd0, 1'b0);
        check("stall.imem_addr", imem_addr, 32'd8);
        check("stall.instr_pc", instr_pc, 32'd0);
        repeat (6) step(1'b0, 32'd0, 1'b1);
        check_issued("drain", 32'd0, 32'd4, 32'd8, 32'd12, 4);

        // Redirect colliding with a pop flushes and realigns the target.
        do_reset();
        repeat (2) step(1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b1);
        check("pre_redir.instr_pc", instr_pc, 32'd4);
        step(1'b1, 32'd2, 1'b1);
        check("redir.imem_addr", imem_addr, 32'd0);
        check("redir.instr_valid", {31'd0, instr_valid}, 32'd0);
        step(1'b0, 32'd0, 1'b1);
        check("post_redir.instr_pc", instr_pc, 32'd0);
        check("post_redir.instr_data", instr_data, 32'h0094_0333);

        // Asynchronous reset between edges with a full FIFO.
        do_reset();
        repeat (2) step(1'b0, 32'd0, 1'b0);
        check("pre_async.instr_valid", {31'd0, instr_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async.instr_valid", {31'd0, instr_valid}, 32'd0);
        check("async.imem_addr", imem_addr, 32'd0);
        model_reset();
        @(negedge clk);
        compare("async_hold");
        @(posedge clk);
        #1;
        reset = 1'b1;
        issued.delete();
        repeat (3) step(1'b0, 32'd0, 1'b1);
        check_issued("after_async", 32'd0, 32'd4, 32'd0, 32'd0, 2);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic        rv;
            logic [31:0] rp;
            logic        rdy;
            rv  = ($urandom_range(0, 7) == 0);
            rp  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 23));
            rdy = ($urandom_range(0, 3) != 0);
            step(rv, rp, rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
